dmem_ctrl: RTL and testbench
============================

Name: dmem_ctrl

Overview:
- Parametrised data-memory controller for the cqu_mips core; replaces the bare single-port RAM hookup with a request/response unit.
- Owns a byte-enabled synchronous RAM, generates byte lanes from MIPS load/store size, and sign/zero-extends loads.
- Detects misaligned and out-of-range accesses and offers configurable RAM read latency.
- Sits between the datapath MEM stage and storage. The datapath stalls on req_ready / rsp_valid.

Parameters:
- ADDR_W, 17, byte-address width of req_addr.
- DEPTH, 32768, number of 32-bit words stored; DEPTH*4 must be <= 2**ADDR_W.
- RD_LAT, 1, RAM read latency in cycles (1..4) between read issue and data valid.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_signed  in  1  loads only: 1 = sign-extend (LB/LH), 0 = zero-extend (LBU/LHU).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  access faulted; memory untouched.

Behaviour:
- Reset: state=IDLE, req_ready=0 during reset then 1 in IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not reset. Reset asserted mid-access aborts the access. An in-flight write already clocked into the RAM stays written.
- Accept: a request is accepted on a rising edge with req_valid && req_ready. req_ready = (state==IDLE).
- Fault: a request faults when any of these holds:
  - req_size==11;
  - half access with addr[0]!=0;
  - word access with addr[1:0]!=0;
  - addr[ADDR_W-1:2] >= DEPTH.
- Byte order is little-endian: byte lane k = addr[1:0], half lane = addr[1].
- States:
  - IDLE: on accept of a fault, go to RESP with rsp_err=1, no RAM access. On an accepted store, write RAM in the same edge with byte enables (byte: 0001<<addr[1:0]; half: 0011<<{addr[1],0}; word: 1111) and replicated data, then go to RESP with rsp_err=0. On an accepted load, issue the RAM read, load the counter with RD_LAT-1, and go to RD_WAIT.
  - RD_WAIT: decrement the counter each cycle. When the RAM data is valid (RD_LAT cycles after issue), capture and extend into rsp_rdata, then go to RESP.
  - RESP: rsp_valid=1, outputs held stable until rsp_valid && rsp_ready, then go to IDLE. rsp_rdata/rsp_err clear to 0 on that edge.
- Latency, accept edge to rsp_valid: store/fault = 1 cycle; load = RD_LAT+1 cycles.
- Throughput: one outstanding request. A new accept is only possible in the cycle after the response handshake completes.
- Extension: byte → bit 7 replicated into [31:8] if signed, else 0; half → bit 15 into [31:16]; word passed unchanged. req_signed is ignored for stores and words.
- Latched fields: req_size, req_signed, and addr[1:0] are latched on accept. Input changes while not ready are ignored.
- rsp_ready held low: the response is held indefinitely and req_ready stays 0.

Decomposition:
- Shared package dmem_pkg: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), state encoding (IDLE/RD_WAIT/RESP), byte-enable and extension helper functions.
- Sub-module dmem_bank: DEPTH x 32 RAM with 4 byte write enables, read pipeline of RD_LAT registers. It has no reset on the array and resets the pipeline valid bits only.

Test Plan:
- SW 0xDEADBEEF @0x10, then LW @0x10 (RD_LAT=1) → store rsp 1 cycle after accept, err=0; load rsp 2 cycles after accept, rdata=0xDEADBEEF.
- SB 0x80 @0x13 over word 0x11223344 @0x10 → LW @0x10 returns 0x80223344; LB @0x13 returns 0xFFFFFF80; LBU @0x13 returns 0x00000080.
- SH 0x8001 @0x22, then LH @0x22 → 0xFFFF8001; LHU → 0x00008001; LW @0x20 shows upper half 0x8001 and lower half unchanged.
- LW @0x11, SH @0x23, size=11 @0x0, LW @(DEPTH*4) → each rsp_err=1 and rdata=0 after 1 cycle; a follow-up LW at the target word shows no modification.
- RD_LAT=3 build plus rsp_ready held low 5 cycles → rsp_valid at accept+4 and stable while stalled; req_ready=0 until the handshake; next request accepted the cycle after.
- Assert rst during RD_WAIT → rsp_valid=0, req_ready=1 after release, no spurious response; a subsequent LW returns correct data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
//   size_e       MIPS access size encoding carried on req_size
//   ST_*         controller state encoding
//   byte_en      byte-lane write enables for a store
//   wdata_rep    replicates right-aligned store data onto every lane
//   load_ext     selects the addressed lane of a read word and extends it
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_BAD  = 2'b11
    } size_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP    = 2'd2;

    // Little-endian: byte lane = off, half lane = off[1].
    function automatic logic [3:0] byte_en(size_e sz, logic [1:0] off);
        case (sz)
            SZ_BYTE: byte_en = 4'b0001 << off;
            SZ_HALF: byte_en = 4'b0011 << {off[1], 1'b0};
            SZ_WORD: byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

    // Replicating lets the RAM use the same data bus for every lane; only
    // the enabled lanes actually land.
    function automatic logic [31:0] wdata_rep(size_e sz, logic [31:0] d);
        case (sz)
            SZ_BYTE: wdata_rep = {4{d[7:0]}};
            SZ_HALF: wdata_rep = {2{d[15:0]}};
            default: wdata_rep = d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(size_e sz, logic sgn, logic [1:0] off,
                                             logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_BYTE: load_ext = {{24{sgn & b[7]}}, b};
            SZ_HALF: load_ext = {{16{sgn & h[15]}}, h};
            default: load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Request/response bus between the MEM stage (master) and dmem_ctrl (slave).
//   req_*  : valid/ready request channel (we, size, signed, byte addr, wdata)
//   rsp_*  : valid/ready response channel (extended rdata, err)
interface dmem_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bank.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and a read pipeline
// of RD_LAT registers.
//   clk, rst  clock / async active-high reset (pipeline valid bits only)
//   we, be    write strobe and byte-lane enables
//   addr      word address shared by read and write
//   wdata     lane-replicated write data
//   rd_en     read issue; rd_valid/rdata appear RD_LAT cycles later
module dmem_bank #(
    parameter int DEPTH  = 32768,
    parameter int RD_LAT = 1,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic          rd_en,
    output logic [31:0]   rdata,
    output logic          rd_valid
);
    logic [31:0]       mem [DEPTH];
    logic [31:0]       pipe_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_v;

    // Array and data stages carry no reset so they map onto RAM/plain flops.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
        if (rd_en) pipe_d[0] <= mem[addr];
        for (int i = 1; i < RD_LAT; i++) pipe_d[i] <= pipe_d[i-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= rd_en;
            for (int i = 1; i < RD_LAT; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    assign rdata    = pipe_d[RD_LAT-1];
    assign rd_valid = pipe_v[RD_LAT-1];
endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store at a time on the slave side
// of dmem_ctrl_if, checks alignment and range, drives the byte-enabled bank
// and returns extended load data or an error flag.
//   clk  clock
//   rst  async active-high reset
//   bus  dmem_ctrl_if.slave (request and response channels)
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_IDLE    | req_ready=1; stores write and faults resolve on the accept edge
//   ST_RD_WAIT | load issued; down-counter runs to 0, then read data captured
//   ST_RESP    | rsp_valid=1, outputs held until rsp_ready
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 17,
    parameter int DEPTH  = 32768,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    dmem_ctrl_if.slave bus
);
    localparam int BANK_AW = $clog2(DEPTH);
    localparam int CNT_W   = 2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    size_e            sz_q;
    logic             sgn_q;
    logic [1:0]       off_q;
    logic [31:0]      rdata_q;
    logic             err_q;

    size_e       req_sz;
    logic        accept;
    logic        out_of_range;
    logic        fault;
    logic        bank_we;
    logic        bank_rd;
    logic [31:0] bank_rdata;
    logic        bank_valid;

    assign req_sz = size_e'(bus.req_size);

    // Held low while rst is asserted even though state already reads IDLE.
    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;

    assign out_of_range = (bus.req_addr >> 2) >= ADDR_W'(DEPTH);

    always_comb begin
        fault = 1'b0;
        case (req_sz)
            SZ_HALF: fault = bus.req_addr[0];
            SZ_WORD: fault = |bus.req_addr[1:0];
            SZ_BAD:  fault = 1'b1;
            default: fault = 1'b0;
        endcase
        if (out_of_range) fault = 1'b1;
    end

    assign bank_we = accept && bus.req_we && !fault;
    assign bank_rd = accept && !bus.req_we && !fault;

    dmem_bank #(
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) u_bank (
        .clk      (clk),
        .rst      (rst),
        .we       (bank_we),
        .be       (byte_en(req_sz, bus.req_addr[1:0])),
        .addr     (bus.req_addr[BANK_AW+1:2]),
        .wdata    (wdata_rep(req_sz, bus.req_wdata)),
        .rd_en    (bank_rd),
        .rdata    (bank_rdata),
        .rd_valid (bank_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sz_q    <= SZ_BYTE;
            sgn_q   <= 1'b0;
            off_q   <= 2'b00;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sz_q  <= req_sz;
                        sgn_q <= bus.req_signed;
                        off_q <= bus.req_addr[1:0];
                        if (fault) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                            state   <= ST_RESP;
                        end else if (bus.req_we) begin
                            err_q   <= 1'b0;
                            rdata_q <= '0;
                            state   <= ST_RESP;
                        end else begin
                            cnt   <= CNT_W'(RD_LAT - 1);
                            state <= ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt == '0) begin
                        if (bank_valid) begin
                            rdata_q <= load_ext(sz_q, sgn_q, off_q, bank_rdata);
                            err_q   <= 1'b0;
                            state   <= ST_RESP;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (RD_LAT=1 and RD_LAT=3, DEPTH=1024)
// share one stimulus driver; sel picks which one sees req_valid.
module tb_dmem_ctrl;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [16:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_ready;

    logic        cur_req_ready;
    logic        cur_rsp_valid;
    logic [31:0] cur_rsp_rdata;
    logic        cur_rsp_err;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    dmem_ctrl_if #(.ADDR_W(17)) if_a ();
    dmem_ctrl_if #(.ADDR_W(17)) if_b ();

    dmem_ctrl #(.ADDR_W(17), .DEPTH(1024), .RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    dmem_ctrl #(.ADDR_W(17), .DEPTH(1024), .RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    assign if_a.req_valid  = req_valid & ~sel;
    assign if_b.req_valid  = req_valid & sel;
    assign if_a.req_we     = req_we;
    assign if_b.req_we     = req_we;
    assign if_a.req_size   = req_size;
    assign if_b.req_size   = req_size;
    assign if_a.req_signed = req_signed;
    assign if_b.req_signed = req_signed;
    assign if_a.req_addr   = req_addr;
    assign if_b.req_addr   = req_addr;
    assign if_a.req_wdata  = req_wdata;
    assign if_b.req_wdata  = req_wdata;
    assign if_a.rsp_ready  = rsp_ready;
    assign if_b.rsp_ready  = rsp_ready;

    assign cur_req_ready = sel ? if_b.req_ready : if_a.req_ready;
    assign cur_rsp_valid = sel ? if_b.rsp_valid : if_a.rsp_valid;
    assign cur_rsp_rdata = sel ? if_b.rsp_rdata : if_a.rsp_rdata;
    assign cur_rsp_err   = sel ? if_b.rsp_err   : if_a.rsp_err;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [16:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
        string       name;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        ntests++;
        nfail++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [16:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_err, input string name);
        exp_t e;
        int   acc;
        int   waited;
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.lat   = (we || exp_err) ? 1 : (sel ? 4 : 2);
        e.name  = name;
        sb.push_back(e);

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        waited = 0;
        while (!cur_req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cur_req_ready) begin
            timeout({name, " accept"});
            req_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        acc = cyc;

        @(negedge clk);
        waited = 0;
        while (!cur_rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!cur_rsp_valid) begin
            timeout({name, " rsp"});
            void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk({e.name, " rdata"}, cur_rsp_rdata, e.rdata);
        chk({e.name, " err"}, 32'(cur_rsp_err), 32'(e.err));
        chk({e.name, " lat"}, 32'(cyc - acc + 1), 32'(e.lat));
    endtask

    initial begin
        int acc;
        int waited;

        rst        = 1'b1;
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        //            we    size   sgn   addr      wdata          exp_rd         err
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h000, 32'h55AA55AA, 32'h00000000, 1'b0, "sw_00"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, "sw_10"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h010, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h010, 32'h11223344, 32'h00000000, 1'b0, "sw_10b"});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 17'h013, 32'h00000080, 32'h00000000, 1'b0, "sb_13"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h010, 32'h0,        32'h80223344, 1'b0, "lw_10_sb"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 17'h013, 32'h0,        32'hFFFFFF80, 1'b0, "lb_13"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 17'h013, 32'h0,        32'h00000080, 1'b0, "lbu_13"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 17'h010, 32'h0,        32'h00000044, 1'b0, "lb_10"});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 17'h012, 32'h0,        32'h00000022, 1'b0, "lbu_12"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h020, 32'hCAFEBABE, 32'h00000000, 1'b0, "sw_20"});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 17'h022, 32'h12348001, 32'h00000000, 1'b0, "sh_22"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 17'h022, 32'h0,        32'hFFFF8001, 1'b0, "lh_22"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 17'h022, 32'h0,        32'h00008001, 1'b0, "lhu_22"});
        vecs.push_back('{1'b0, 2'b10, 1'b1, 17'h020, 32'h0,        32'h8001BABE, 1'b0, "lw_20"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 17'h020, 32'h0,        32'hFFFFBABE, 1'b0, "lh_20"});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 17'h020, 32'h0,        32'h0000BABE, 1'b0, "lhu_20"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h011, 32'h0,        32'h00000000, 1'b1, "lw_mis"});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 17'h023, 32'h0000FFFF, 32'h00000000, 1'b1, "sh_mis"});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 17'h000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "sz_bad"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h1000, 32'h0,       32'h00000000, 1'b1, "lw_oor"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h1000, 32'h99999999, 32'h00000000, 1'b1, "sw_oor"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h012, 32'h00000000, 32'h00000000, 1'b1, "sw_mis"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h010, 32'h0,        32'h80223344, 1'b0, "lw_10_keep"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h020, 32'h0,        32'h8001BABE, 1'b0, "lw_20_keep"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h000, 32'h0,        32'h55AA55AA, 1'b0, "lw_00_keep"});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 17'h0FFC, 32'h01828384, 32'h00000000, 1'b0, "sw_last"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h0FFC, 32'h0,       32'h01828384, 1'b0, "lw_last"});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 17'h0FFD, 32'h0,       32'hFFFFFF83, 1'b0, "lb_last"});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 17'h0FFE, 32'h0,       32'h00000182, 1'b0, "lh_last"});
        vecs.push_back('{1'b1, 2'b00, 1'b1, 17'h020, 32'hFFFFFF7F, 32'h00000000, 1'b0, "sb_20"});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 17'h020, 32'h0,        32'h8001BA7F, 1'b0, "lw_20_sb"});

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst req_ready_a", 32'(if_a.req_ready), 32'd0);
        chk("rst req_ready_b", 32'(if_b.req_ready), 32'd0);
        chk("rst rsp_valid_a", 32'(if_a.rsp_valid), 32'd0);
        chk("rst rsp_rdata_a", if_a.rsp_rdata, 32'd0);
        chk("rst rsp_err_a",   32'(if_a.rsp_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post rst req_ready_a", 32'(if_a.req_ready), 32'd1);
        chk("post rst req_ready_b", 32'(if_b.req_ready), 32'd1);

        // Table on the RD_LAT=1 instance
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, vecs[i].exp_err, vecs[i].name);
        end

        // RD_LAT=3 instance: stalled response
        sel = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 17'h040, 32'hA5A51234, 32'h0, 1'b0, "b_sw_40");
        do_req(1'b0, 2'b10, 1'b0, 17'h042, 32'h0, 32'h0, 1'b1, "b_lw_mis");

        @(negedge clk);
        rsp_ready  = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_size   = 2'b10;
        req_signed = 1'b0;
        req_addr   = 17'h040;
        chk("stall ready before", 32'(cur_req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        @(negedge clk);
        waited = 0;
        while (!cur_rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("stall lat", 32'(cyc - acc + 1), 32'd4);
        chk("stall rdata", cur_rsp_rdata, 32'hA5A51234);
        // A different request waits on the bus while the response is stalled.
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_size   = 2'b10;
        req_addr   = 17'h044;
        req_wdata  = 32'h0BADF00D;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d valid", i), 32'(cur_rsp_valid), 32'd1);
            chk($sformatf("stall%0d rdata", i), cur_rsp_rdata, 32'hA5A51234);
            chk($sformatf("stall%0d ready", i), 32'(cur_req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        chk("stall ready at release", 32'(cur_req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("after hs valid", 32'(cur_rsp_valid), 32'd0);
        chk("after hs rdata", cur_rsp_rdata, 32'd0);
        chk("after hs ready", 32'(cur_req_ready), 32'd1);
        @(posedge clk);
        #1;
        acc = cyc;
        req_valid = 1'b0;
        @(negedge clk);
        chk("next sw valid", 32'(cur_rsp_valid), 32'd1);
        chk("next sw err", 32'(cur_rsp_err), 32'd0);
        chk("next sw lat", 32'(cyc - acc + 1), 32'd1);

        // Reset during RD_WAIT
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = 2'b10;
        req_addr  = 17'h044;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst mid ready", 32'(cur_req_ready), 32'd0);
        chk("rst mid valid", 32'(cur_rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst rel ready", 32'(cur_req_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("no spurious %0d", i), 32'(cur_rsp_valid), 32'd0);
            @(negedge clk);
        end
        do_req(1'b0, 2'b10, 1'b0, 17'h044, 32'h0, 32'h0BADF00D, 1'b0, "b_lw_44");
        do_req(1'b0, 2'b01, 1'b1, 17'h046, 32'h0, 32'h00000BAD, 1'b0, "b_lh_46");
        do_req(1'b0, 2'b00, 1'b1, 17'h045, 32'h0, 32'hFFFFFFF0, 1'b0, "b_lb_45");

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
